// File: rtl/fb_pkg.sv
// fb_pkg: shared types and defaults for the serial subtractor
//   state_t   : IDLE / RUN / DONE controller states
//   WIDTH_DEF : default operand width
package fb_pkg;
    localparam int WIDTH_DEF = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/fullsubtractor.sv
// fullsubtractor: 1-bit combinational full subtractor
//   a, b : minuend / subtrahend bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module fullsubtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/fb_serial_subtractor.sv
// fb_serial_subtractor: bit-serial LSB-first subtractor {Bout,D} = A - B - Bin
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin an operation (sampled in IDLE only)
//   A, B, Bin: operands and borrow-in, latched on the accepting edge
//   busy     : operation in progress
//   done     : one-cycle result-valid pulse
//   D, Bout  : registered difference and borrow-out, held until next done
module fb_serial_subtractor
    import fb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] sa, sb, sd;
    logic            bor, d_bit, bor_nxt;

    fullsubtractor u_fs (
        .a   (sa[0]),
        .b   (sb[0]),
        .bin (bor),
        .d   (d_bit),
        .bout(bor_nxt)
    );

    // RUN spends WIDTH edges shifting bits, then one edge committing the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sa    <= '0;
            sb    <= '0;
            sd    <= '0;
            bor   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            D     <= '0;
            Bout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= A;
                        sb    <= B;
                        bor   <= Bin;
                        sd    <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cnt != CW'(WIDTH)) begin
                        sa  <= sa >> 1;
                        sb  <= sb >> 1;
                        sd  <= {d_bit, sd[WIDTH-1:1]};
                        bor <= bor_nxt;
                        cnt <= cnt + CW'(1);
                    end else begin
                        D     <= sd;
                        Bout  <= bor;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_serial_subtractor.sv
// tb_fb_serial_subtractor: self-checking bench with a cycle-level reference model
module tb_fb_serial_subtractor;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, start, Bin, busy, done, Bout;
    logic [W-1:0] A, B, D;

    int checks = 0;
    int errors = 0;

    fb_serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .Bin  (Bin),
        .busy (busy),
        .done (done),
        .D    (D),
        .Bout (Bout)
    );

    always #5 clk = ~clk;

    // model: age counts edges since the accepting edge, -1 when idle;
    // busy for ages 0..W, done and result visible at age W+1
    int         age  = -1;
    logic [W:0] pend = '0;
    logic [W:0] mres = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            age  = -1;
            mres = '0;
        end else if (age < 0) begin
            if (start) begin
                age  = 0;
                pend = ({1'b0, A} - {1'b0, B}) - {{W{1'b0}}, Bin};
            end
        end else if (age == W + 1) begin
            age = -1;
        end else begin
            age = age + 1;
            if (age == W + 1) mres = pend;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    bit en = 1'b1;
    bit sweep = 1'b0;
    int cyc = 0;
    int last_done = -1;
    int dones = 0;

    // done pulses under a held start are separated by WIDTH+2 non-done cycles
    always @(negedge clk) begin
        cyc++;
        if (en) begin
            chk("busy", busy, (age >= 0 && age <= W));
            chk("done", done, (age == W + 1));
            chk("D", D, mres[W-1:0]);
            chk("Bout", Bout, mres[W]);
        end
        if (done === 1'b1) begin
            dones++;
            if (sweep && last_done >= 0) chk("done_gap", cyc - last_done, W + 3);
            last_done = cyc;
        end
    end

    task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                      input logic [W-1:0] ed, input logic eb, input string nm, input bit tog);
        int lat, d0;
        A = a;
        B = b;
        Bin = bi;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        d0 = dones;
        lat = 0;
        for (int i = 0; i < 20 && done !== 1'b1; i++) begin
            @(posedge clk);
            #1 lat++;
            if (tog) begin
                A = ~A;
                B = ~B;
                Bin = ~Bin;
                start = (lat == 2);
            end
        end
        chk({nm, "_lat"}, lat, W + 1);
        chk({nm, "_D"}, D, ed);
        chk({nm, "_Bout"}, Bout, eb);
        chk({nm, "_model"}, mres, {eb, ed});
        repeat (3) @(posedge clk);
        #2 chk({nm, "_pulses"}, dones - d0, 1);
    endtask

    initial begin
        int d0, k;
        bit ok;
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        Bin = 1'b0;
        @(posedge clk);
        #1 chk("rst_D", D, 0);
        chk("rst_Bout", Bout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #2;
        go(4'h7, 4'h3, 1'b0, 4'h4, 1'b0, "t1", 1'b0);
        go(4'h3, 4'h7, 1'b0, 4'hC, 1'b1, "t2a", 1'b0);
        go(4'h0, 4'h0, 1'b1, 4'hF, 1'b1, "t2b", 1'b0);

        A = 4'h5;
        B = 4'h1;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("abort_D", D, 0);
        chk("abort_Bout", Bout, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        d0 = dones;
        @(posedge clk);
        #2 rst = 1'b0;
        go(4'h9, 4'h2, 1'b0, 4'h7, 1'b0, "t4", 1'b0);
        chk("abort_nodone", dones - d0, 1);

        go(4'hF, 4'hF, 1'b0, 4'h0, 1'b0, "t3", 1'b1);

        sweep = 1'b1;
        last_done = -1;
        d0 = dones;
        ok = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 512; i++) begin
            {A, B, Bin} = i[8:0];
            for (k = 0; k < 20 && busy !== 1'b0; k++) begin
                @(posedge clk);
                #2;
            end
            if (k == 20) ok = 1'b0;
            for (k = 0; k < 20 && busy !== 1'b1; k++) begin
                @(posedge clk);
                #2;
            end
            if (k == 20) ok = 1'b0;
        end
        start = 1'b0;
        for (k = 0; k < 20 && busy !== 1'b0; k++) begin
            @(posedge clk);
            #2;
        end
        repeat (3) @(posedge clk);
        #2 chk("sweep_accepts", ok, 1);
        chk("sweep_pulses", dones - d0, 512);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
